// File: rtl/fft_peak_analyzer.sv
// Peak-power bin finder for one 16-point complex FFT frame.
// It scans PAR bins per cycle and reports the strongest bin on done/freq/max_mag.
module fft_peak_analyzer #(
    parameter int DW  = 16,
    parameter int NPT = 16,
    parameter int PAR = 2,
    parameter int FW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fft_valid,
    input  logic [2*DW-1:0] fft_d0,
    input  logic [2*DW-1:0] fft_d1,
    input  logic [2*DW-1:0] fft_d2,
    input  logic [2*DW-1:0] fft_d3,
    input  logic [2*DW-1:0] fft_d4,
    input  logic [2*DW-1:0] fft_d5,
    input  logic [2*DW-1:0] fft_d6,
    input  logic [2*DW-1:0] fft_d7,
    input  logic [2*DW-1:0] fft_d8,
    input  logic [2*DW-1:0] fft_d9,
    input  logic [2*DW-1:0] fft_d10,
    input  logic [2*DW-1:0] fft_d11,
    input  logic [2*DW-1:0] fft_d12,
    input  logic [2*DW-1:0] fft_d13,
    input  logic [2*DW-1:0] fft_d14,
    input  logic [2*DW-1:0] fft_d15,
    output logic            in_ready,
    output logic            done,
    output logic [FW-1:0]   freq,
    output logic [2*DW-1:0] max_mag,
    output logic            drop
);

    typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

    localparam logic [FW-1:0] LAST_IDX = FW'(NPT - PAR);
    localparam logic [FW-1:0] STEP     = FW'(PAR);

    state_t          state_q;
    logic [2*DW-1:0] buf_q [NPT];
    logic [FW-1:0]   idx_q;
    logic [FW-1:0]   best_idx_q;
    logic [FW-1:0]   best_idx_d;
    logic [2*DW-1:0] best_mag_q;
    logic [2*DW-1:0] best_mag_d;
    logic            done_q;
    logic [FW-1:0]   freq_q;
    logic [2*DW-1:0] max_mag_q;
    logic            drop_q;
    logic            capture;
    logic [2*DW-1:0] frame_in [NPT];

    assign frame_in[0]  = fft_d0;
    assign frame_in[1]  = fft_d1;
    assign frame_in[2]  = fft_d2;
    assign frame_in[3]  = fft_d3;
    assign frame_in[4]  = fft_d4;
    assign frame_in[5]  = fft_d5;
    assign frame_in[6]  = fft_d6;
    assign frame_in[7]  = fft_d7;
    assign frame_in[8]  = fft_d8;
    assign frame_in[9]  = fft_d9;
    assign frame_in[10] = fft_d10;
    assign frame_in[11] = fft_d11;
    assign frame_in[12] = fft_d12;
    assign frame_in[13] = fft_d13;
    assign frame_in[14] = fft_d14;
    assign frame_in[15] = fft_d15;

    assign in_ready = (state_q != SCAN);
    assign capture  = fft_valid && in_ready;
    assign done     = done_q;
    assign freq     = freq_q;
    assign max_mag  = max_mag_q;
    assign drop     = drop_q;

    // Walk the group in ascending bin order with a strict compare so ties keep the lowest index.
    always_comb begin
        best_mag_d = best_mag_q;
        best_idx_d = best_idx_q;
        for (int j = 0; j < PAR; j++) begin
            logic [FW-1:0]          bin;
            logic signed [2*DW-1:0] re_x;
            logic signed [2*DW-1:0] im_x;
            logic signed [2*DW-1:0] sq_re;
            logic signed [2*DW-1:0] sq_im;
            logic [2*DW-1:0]        pwr;
            bin   = idx_q + FW'(j);
            re_x  = {{DW{buf_q[bin][2*DW-1]}}, buf_q[bin][2*DW-1:DW]};
            im_x  = {{DW{buf_q[bin][DW-1]}}, buf_q[bin][DW-1:0]};
            sq_re = re_x * re_x;
            sq_im = im_x * im_x;
            pwr   = unsigned'(sq_re) + unsigned'(sq_im);
            if (pwr > best_mag_d) begin
                best_mag_d = pwr;
                best_idx_d = bin;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_mag_q <= '0;
            done_q     <= 1'b0;
            freq_q     <= '0;
            max_mag_q  <= '0;
            drop_q     <= 1'b0;
            for (int k = 0; k < NPT; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                end
                SCAN: begin
                    if (fft_valid) begin
                        drop_q <= 1'b1;
                    end
                    best_mag_q <= best_mag_d;
                    best_idx_q <= best_idx_d;
                    idx_q      <= idx_q + STEP;
                    if (idx_q == LAST_IDX) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    done_q    <= 1'b1;
                    freq_q    <= best_idx_q;
                    max_mag_q <= best_mag_q;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            // A capture during FIN overrides the return to IDLE and goes straight back to SCAN.
            if (capture) begin
                for (int k = 0; k < NPT; k++) begin
                    buf_q[k] <= frame_in[k];
                end
                idx_q      <= '0;
                best_idx_q <= '0;
                best_mag_q <= '0;
                state_q    <= SCAN;
            end
        end
    end

endmodule

// File: doc/fft_peak_analyzer.md
Name: fft_peak_analyzer

Overview:
- Consumer end of the FAS FFT output bundle: takes one 16-point complex frame on fft_valid and finds the bin with the largest power (real² + imag²).
- Reports that bin on done/freq, the same result interface the FAS top exposes.
- Sits after the FFT stage and drives the top-level done/freq pins. It is also reusable as a bench-side reference monitor.

Parameters:
- DW, 16, width of each real/imag component (signed, 8.8 fixed point)
- NPT, 16, points per frame (fixed at 16 in this revision)
- PAR, 2, bins evaluated per scan cycle; must divide NPT
- FW, 4, width of freq output (log2 NPT)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset: **asynchronous, active-low**
- fft_valid  in  1  one-cycle strobe; fft_d0..fft_d15 valid this cycle
- fft_d0 .. fft_d15  in  32 each  bin k = {real[31:16], imag[15:0]}, two's complement
- in_ready  out  1  high when a frame presented now will be captured
- done  out  1  one-cycle pulse, result valid
- freq  out  FW  index of peak-power bin; held until the next done
- max_mag  out  2*DW  peak power value (unsigned); held with freq
- drop  out  1  sticky, set when a frame arrives while in_ready=0; cleared only by reset

Behaviour:
- Reset (rst=0), asynchronous with immediate effect:
  - state=IDLE; frame buffer, idx, best_idx and best_mag cleared.
  - done=0, freq=0, max_mag=0, drop=0, in_ready=1.
  - A reset mid-scan discards the frame and produces no done.
- States: IDLE, SCAN, FIN.
- in_ready = (state != SCAN), purely from the registered state.
- Capture:
  - Condition: fft_valid=1 and in_ready=1 at edge E0.
  - Action: latch all 16 words, idx=0, best_mag=0, best_idx=0, state=SCAN.
- Drop:
  - Condition: fft_valid=1 with in_ready=0.
  - Action: frame ignored, drop<=1; in-flight scan unaffected.
- SCAN:
  - Each edge evaluates bins idx .. idx+PAR-1, then idx += PAR.
  - After NPT/PAR edges (E1..E8 at defaults) state=FIN.
- Power per bin: re*re + im*im.
  - Each product is signed DW×DW, non-negative; sum held unsigned in 2*DW bits.
  - Max value 2×2^30 = 0x80000000, so there is no overflow.
  - No rounding or truncation.
- Compare: a candidate replaces best only if strictly greater. Ties keep the lowest index, both within a PAR group and across cycles.
- FIN (one cycle, edge E9 at defaults):
  - done<=1; freq<=best_idx; max_mag<=best_mag.
  - done is high for exactly the cycle after E9, then returns to 0.
- Back-to-back: a frame presented during the FIN cycle (in_ready=1) is captured.
  - State goes directly to SCAN. The current done/freq still update on that edge.
  - Minimum accepted frame spacing = NPT/PAR+1 cycles (9 at defaults).
- Latency: fft_valid sampled at E0 to done visible after E(NPT/PAR+1).
- freq and max_mag change only on the edge that raises done.
- Both are undefined-free: never X after reset.

Test Plan:
1. Bin 5 = {0x0300,0x0400}, all other bins 0 -> done pulses 9 cycles after capture, freq=5, max_mag=0x00190000, drop=0.
2. All bins 0 -> freq=0, max_mag=0x00000000, done pulses once.
3. Bins 3 and 12 both {0x0100,0x0000}; also bins 6 and 7 both {0x0080,0x0000} as a within-pair tie -> freq=3, max_mag=0x00010000.
   - Second frame with only bins 6 and 7 set -> freq=6.
4. Bin 15 = {0x8000,0x8000}, others {0x7FFF,0x0000} -> freq=15, max_mag=0x80000000 (no wrap).
5. Frames at 4-cycle spacing:
   - Second frame dropped: drop=1 and stays 1; in_ready=0 during SCAN; the first result is correct and unchanged.
   - Frames at exactly 9-cycle spacing (capture during FIN) -> both accepted, two done pulses 9 cycles apart, drop stays 0.
6. rst=0 asserted off-edge at scan cycle 4 -> done/freq/max_mag/in_ready read 0/0/0/1 before the next clk edge, with no done pulse.
   - After release, the frame from test 1 is re-sent -> freq=5.
